uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Word-to-serial UART transmitter: accepts a burst of 1..4 32-bit words from the bus side, buffers them as bytes and shifts them out on `tx`.
- Frame format is 8N1, LSB first: start bit 0, eight data bits, stop bit 1.
- Transmit-side counterpart of the UART receive path. Byte order within a word is little-endian (byte 0 = data[7:0] goes on the line first), matching the receiver's word packing.

Parameters:
- DIV_RATE, 16: clock cycles per bit period, ≥2.
- FIFO_WORDS, 4: buffer depth in words; byte depth is FIFO_WORDS*4.
- WNUM_W, 3: width of `word_number`.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE
- word_number  in  WNUM_W  number of words in the burst, sampled with `start`
- word_data  in  32  word from bus master
- word_valid  in  1  `word_data` valid
- word_ready  out  1  block accepts a word this cycle
- tx  out  1  serial line, idles high
- busy  out  1  burst in progress (all states except IDLE)
- done  out  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset (async, resetn=0): state=IDLE, tx=1, word_ready=0, busy=0, done=0, all counters 0. Reset mid-frame aborts the burst; tx goes to 1 immediately. No partial byte is resumed.
- Latched limit: `byte_limit` = min(word_number, FIFO_WORDS)*4, computed at start. Larger word_number is clamped.
- IDLE:
  - tx=1, done=0.
  - On start=1 with word_number=0: done pulses next cycle, stay IDLE.
  - On start=1 with word_number≠0: latch the limit, clear wr/rd byte counters, go to LOAD.
- LOAD:
  - word_ready=1 while wr_cnt<byte_limit.
  - Handshake word_valid&&word_ready writes 4 bytes at wr_cnt..wr_cnt+3 (data[7:0] first) and adds 4 to wr_cnt.
  - When wr_cnt reaches byte_limit: word_ready drops in the same cycle the count updates (registered; no extra word accepted), go to START.
  - Holes in word_valid simply stall.
- START: tx=0 for DIV_RATE cycles. Load the shift register from fifo[rd_cnt], set bit_cnt=0, go to DATA.
- DATA:
  - tx=shift[0], held DIV_RATE cycles.
  - Then shift right by one and increment bit_cnt.
  - After bit 7 completes, go to STOP.
- STOP:
  - tx=1 for DIV_RATE cycles, then rd_cnt+1.
  - If rd_cnt+1<byte_limit, go to START (no idle gap beyond the stop bit).
  - Otherwise go to IDLE with done=1 for exactly one cycle.
- Bit timing: a divider counts DIV_RATE-1 down to 0. The bit boundary is at 0, where the divider reloads. Every bit is exactly DIV_RATE cycles; a full frame is 10*DIV_RATE cycles.
- tx is registered, glitch-free, and changes only at bit boundaries or on reset.
- Transmission does not start until the whole burst is buffered. There is no overlap of LOAD with serialisation.
- `start` outside IDLE is ignored.
- Counter widths are log2(FIFO_WORDS*4)+1 bits; no wrap occurs because byte_limit ≤ depth.
- Total burst latency from last accepted word to done: byte_limit*10*DIV_RATE + 1 cycles.

Decomposition:
- Shared UART header:
  - state encodings UART_TX_IDLE/LOAD/START/DATA/STOP;
  - TX_START_BIT=0, TX_STOP_BIT=1;
  - default DIV_RATE;
  - byte width 8, word width 32.
- Sub-module `uart_baud_div`: divider counter with a `tick` output asserted on the last cycle of a bit period and a synchronous `reload` input. The remaining logic stays in uart_tx.

Test Plan:
1. DIV_RATE=4, start with word_number=1, word 0x000000A5 → tx = 0 then bits 1,0,1,0,0,1,0,1 then 1, each 4 cycles. This is followed by three further frames of 0x00 at 40-cycle spacing, then a done pulse; 160 tx cycles total.
2. word_number=2, words 0x44332211, 0x88776655 → decoded bytes in order 11,22,33,44,55,66,77,88. word_ready drops after the 2nd handshake. done fires once.
3. word_valid toggling 1-0-0-1 during LOAD with word_number=2 → exactly 2 words accepted. tx stays 1 until the second is accepted.
4. word_number=0 → no tx activity. done pulses one cycle after start. busy stays 0.
5. word_number=7 (clamped to 4) → exactly 4 handshakes, 16 frames.
6. resetn asserted during DATA of the 2nd byte → tx=1 immediately, busy=0. A new start afterwards transmits a fresh burst correctly.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART transmit definitions: FSM encodings, line levels, widths and
// the burst-size clamp used when a burst is started.
package uart_tx_pkg;

  localparam logic [2:0] UART_TX_IDLE  = 3'd0;
  localparam logic [2:0] UART_TX_LOAD  = 3'd1;
  localparam logic [2:0] UART_TX_START = 3'd2;
  localparam logic [2:0] UART_TX_DATA  = 3'd3;
  localparam logic [2:0] UART_TX_STOP  = 3'd4;

  localparam logic TX_START_BIT = 1'b0;
  localparam logic TX_STOP_BIT  = 1'b1;

  localparam int UART_DIV_RATE = 16;
  localparam int BYTE_W        = 8;
  localparam int WORD_W        = 32;

  function automatic int clamp_words(input int wnum, input int max_words);
    return (wnum > max_words) ? max_words : wnum;
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Bit-period divider: counts DIV_RATE-1 down to 0, tick is high on the last
// cycle of each bit period; reload restarts a fresh period.
module uart_baud_div #(
  parameter int DIV_RATE = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic reload,
  output logic tick
);

  localparam int CW = (DIV_RATE > 2) ? $clog2(DIV_RATE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_RATE - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          tick_r;

  // Next divider value: reload on request or at the bit boundary.
  always_comb begin
    cnt_next_s = cnt_r;
    if (reload || (cnt_r == {CW{1'b0}})) begin
      cnt_next_s = LAST;
    end else begin
      cnt_next_s = cnt_r - CW'(1);
    end
  end

  // Divider state and registered boundary flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (cnt_next_s == {CW{1'b0}});
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_tx.sv
// Burst UART transmitter: buffers 1..FIFO_WORDS words, then sends the bytes
// little-endian as 8N1 frames. FIFO_WORDS must be a power of two >= 2.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DIV_RATE   = UART_DIV_RATE,
  parameter int FIFO_WORDS = 4,
  parameter int WNUM_W     = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [WNUM_W-1:0] word_number,
  input  logic [31:0]       word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = FIFO_WORDS * 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [2:0]        state_r;
  logic [CNT_W-1:0]  wr_cnt_r;
  logic [CNT_W-1:0]  rd_cnt_r;
  logic [CNT_W-1:0]  limit_r;
  logic [2:0]        bit_cnt_r;
  logic [BYTE_W-1:0] shift_r;
  logic [WORD_W-1:0] fifo_r [FIFO_WORDS];
  logic              tx_r;
  logic              word_ready_r;
  logic              busy_r;
  logic              done_r;

  logic [CNT_W-1:0]  limit_s;
  logic [CNT_W-1:0]  wr_next_s;
  logic [CNT_W-1:0]  rd_next_s;
  logic [BYTE_W-1:0] rd_byte_s;
  logic              accept_s;
  logic              reload_s;
  logic              tick_s;

  // Divider is held in reload until serialisation begins, so START gets a full period.
  assign reload_s = (state_r == UART_TX_IDLE) || (state_r == UART_TX_LOAD);

  uart_baud_div #(.DIV_RATE(DIV_RATE)) u_baud_div (
    .clk    (clk),
    .resetn (resetn),
    .reload (reload_s),
    .tick   (tick_s)
  );

  // Burst limit, counter increments and the byte addressed by rd_cnt.
  always_comb begin
    limit_s   = CNT_W'(clamp_words(int'(word_number), FIFO_WORDS) * 4);
    wr_next_s = wr_cnt_r + CNT_W'(4);
    rd_next_s = rd_cnt_r + CNT_W'(1);
    accept_s  = (state_r == UART_TX_LOAD) && word_valid && word_ready_r;
    rd_byte_s = fifo_r[rd_cnt_r[CNT_W-2:2]][{rd_cnt_r[1:0], 3'b000} +: BYTE_W];
  end

  // Word buffer; contents are don't-care until written during LOAD.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      fifo_r[wr_cnt_r[CNT_W-2:2]] <= word_data;
    end
  end

  // Burst sequencer and registered line/handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= UART_TX_IDLE;
      wr_cnt_r     <= {CNT_W{1'b0}};
      rd_cnt_r     <= {CNT_W{1'b0}};
      limit_r      <= {CNT_W{1'b0}};
      bit_cnt_r    <= 3'd0;
      shift_r      <= {BYTE_W{1'b0}};
      tx_r         <= TX_STOP_BIT;
      word_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        UART_TX_IDLE: begin
          tx_r <= TX_STOP_BIT;
          if (start) begin
            if (word_number == {WNUM_W{1'b0}}) begin
              done_r <= 1'b1;
            end else begin
              limit_r      <= limit_s;
              wr_cnt_r     <= {CNT_W{1'b0}};
              rd_cnt_r     <= {CNT_W{1'b0}};
              word_ready_r <= 1'b1;
              busy_r       <= 1'b1;
              state_r      <= UART_TX_LOAD;
            end
          end
        end
        UART_TX_LOAD: begin
          if (accept_s) begin
            wr_cnt_r <= wr_next_s;
            if (wr_next_s == limit_r) begin
              word_ready_r <= 1'b0;
              tx_r         <= TX_START_BIT;
              state_r      <= UART_TX_START;
            end
          end
        end
        UART_TX_START: begin
          if (tick_s) begin
            shift_r   <= rd_byte_s;
            tx_r      <= rd_byte_s[0];
            bit_cnt_r <= 3'd0;
            state_r   <= UART_TX_DATA;
          end
        end
        UART_TX_DATA: begin
          if (tick_s) begin
            if (bit_cnt_r == 3'd7) begin
              tx_r    <= TX_STOP_BIT;
              state_r <= UART_TX_STOP;
            end else begin
              shift_r   <= {1'b0, shift_r[BYTE_W-1:1]};
              tx_r      <= shift_r[1];
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        UART_TX_STOP: begin
          if (tick_s) begin
            rd_cnt_r <= rd_next_s;
            if (rd_next_s < limit_r) begin
              tx_r    <= TX_START_BIT;
              state_r <= UART_TX_START;
            end else begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= UART_TX_IDLE;
            end
          end
        end
        default: begin
          state_r      <= UART_TX_IDLE;
          tx_r         <= TX_STOP_BIT;
          word_ready_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready = word_ready_r;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of bursts checked cycle-by-cycle against an
// ideal 8N1 line model, plus zero-length and mid-frame reset sequences.
module tb_uart_tx;

  localparam int DIV = 4;
  localparam int FW  = 4;
  localparam int WW  = 3;
  localparam int FRAME = 10 * DIV;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [WW-1:0] word_number;
  logic [31:0]   word_data;
  logic          word_valid;
  logic          word_ready;
  logic          tx;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          wnum;
    logic [31:0] w [4];
    logic [7:0]  vpat;
    int          exp_hs;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] exp_bytes [$];

  uart_tx #(.DIV_RATE(DIV), .FIFO_WORDS(FW), .WNUM_W(WW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .word_number (word_number),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Ideal line level k cycles after the last accepted word.
  function automatic logic line_level(input int k);
    int pos;
    logic [7:0] b;
    b   = exp_bytes[k / FRAME];
    pos = (k % FRAME) / DIV;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic run_burst(input string name, input int wnum, input logic [31:0] w [4],
                           input logic [7:0] vpat, input int exp_hs, input int abort_at);
    int hs, cyc, nb, n, fi;
    logic take, tx_low, not_busy, bad;
    logic [7:0] got_b;
    nb = (wnum > FW) ? FW : wnum;
    exp_bytes.delete();
    for (int i = 0; i < nb * 4; i++) exp_bytes.push_back(8'(w[i/4] >> (8 * (i % 4))));
    n = nb * 4 * FRAME;

    start = 1'b1; word_number = WW'(wnum); word_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0; cyc = 0; tx_low = 1'b0; not_busy = 1'b0;
    while (cyc < 40) begin
      word_valid = vpat[cyc % 8];
      word_data  = (hs < 4) ? w[hs] : 32'h0;
      @(negedge clk);
      if (tx !== 1'b1) tx_low = 1'b1;
      if (busy !== 1'b1) not_busy = 1'b1;
      take = word_ready && word_valid;
      @(posedge clk); #1;
      cyc++;
      if (take) begin
        hs++;
        if (word_ready !== 1'b1) break;
      end
    end
    word_valid = 1'b0;
    check({name, " handshakes"}, hs, exp_hs);
    check({name, " tx idle/busy in load"}, {tx_low, not_busy}, 2'b00);

    bad = 1'b0; got_b = 8'h00;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (abort_at >= 0 && k == abort_at) break;
      if (tx !== line_level(k) || done !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      if ((k % DIV) == DIV / 2 && (k % FRAME) / DIV >= 1 && (k % FRAME) / DIV <= 8)
        got_b[(k % FRAME) / DIV - 1] = tx;
      if ((k % FRAME) == FRAME - 1) begin
        fi = k / FRAME;
        check($sformatf("%s frame %0d err/byte", name, fi), {bad, got_b}, {1'b0, exp_bytes[fi]});
        bad = 1'b0;
      end
    end

    if (abort_at >= 0) begin
      resetn = 1'b0;
      #1;
      check({name, " async reset tx/busy/done/ready"}, {tx, busy, done, word_ready}, 4'b1000);
      @(posedge clk); @(posedge clk); #1;
      resetn = 1'b1;
    end else begin
      @(negedge clk);
      check({name, " done pulse/busy"}, {done, busy, tx}, 3'b101);
      @(negedge clk);
      check({name, " done one cycle"}, {done, busy}, 2'b00);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic bad;
    logic [31:0] wr [4];
    resetn = 1'b0; start = 1'b0; word_number = '0; word_data = 32'h0; word_valid = 1'b0;
    #12;
    check("reset tx/busy/done/ready", {tx, busy, done, word_ready}, 4'b1000);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    vecs[0].wnum = 1; vecs[0].vpat = 8'hFF; vecs[0].exp_hs = 1;
    vecs[0].w = '{32'h000000A5, 32'h0, 32'h0, 32'h0};
    vecs[1].wnum = 2; vecs[1].vpat = 8'hFF; vecs[1].exp_hs = 2;
    vecs[1].w = '{32'h44332211, 32'h88776655, 32'h0, 32'h0};
    vecs[2].wnum = 2; vecs[2].vpat = 8'b1001_1001; vecs[2].exp_hs = 2;
    vecs[2].w = '{32'hDEADBEEF, 32'h0F1E2D3C, 32'h0, 32'h0};
    vecs[3].wnum = 7; vecs[3].vpat = 8'hFF; vecs[3].exp_hs = 4;
    vecs[3].w = '{32'h03020100, 32'hFFFEFDFC, 32'h5A5AA5A5, 32'h80402010};
    for (int i = 4; i < 6; i++) begin
      vecs[i].wnum = (i == 4) ? int'($urandom_range(1, 7)) : int'($urandom_range(1, 3));
      vecs[i].vpat = 8'($urandom) | 8'h01;
      vecs[i].exp_hs = (vecs[i].wnum > FW) ? FW : vecs[i].wnum;
      for (int j = 0; j < 4; j++) vecs[i].w[j] = $urandom;
    end

    for (int i = 0; i < 6; i++)
      run_burst($sformatf("v%0d", i), vecs[i].wnum, vecs[i].w, vecs[i].vpat, vecs[i].exp_hs, -1);

    // Zero-length burst: only a done pulse, line untouched.
    start = 1'b1; word_number = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero done/busy/tx", {done, busy, tx}, 3'b101);
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1 || word_ready !== 1'b0) bad = 1'b1;
    end
    check("zero quiet line", bad, 1'b0);
    @(posedge clk); #1;

    // Reset while the second byte's data bits are on the line, then a fresh burst.
    wr = '{32'h3C5A96C3, 32'h12345678, 32'h0, 32'h0};
    run_burst("abort", 2, wr, 8'hFF, 2, FRAME + DIV + 5);
    wr = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0};
    run_burst("after reset", 1, wr, 8'hFF, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
